// File: rtl/rr_arb_pkg.sv
// Shared types and width helper for the round-robin array arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rr_state_e;

  function automatic int rr_idw(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr is at bit 0,
// find the lowest set bit, then rotate the index back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int W   = 4,
  parameter int IDW = rr_idw(W)
) (
  input  logic           req_valid [W-1:0],
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           hit
);

  if (W == 1) begin : g_single
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign sel        = '0;
    assign hit        = req_valid[0];
  end else begin : g_multi
    localparam int SW = IDW + 1;

    logic [W-1:0]   rot;
    logic [IDW-1:0] first;
    logic [SW-1:0]  rsum;
    logic [SW-1:0]  usum;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default at the top, so no path leaves a value held (no latch).
    always_comb begin
      rot  = '0;
      rsum = '0;
      for (int j = 0; j < W; j++) begin
        rsum = {1'b0, ptr} + SW'(j);
        if (rsum >= SW'(W)) rsum = rsum - SW'(W);
        rot[j] = req_valid[rsum[IDW-1:0]];
      end

      first = '0;
      for (int j = W - 1; j >= 0; j--) begin
        if (rot[j]) first = IDW'(j);
      end
      hit = |rot;

      // Explicit wrap keeps non-power-of-two W correct.
      usum = {1'b0, ptr} + {1'b0, first};
      if (usum >= SW'(W)) usum = usum - SW'(W);
      sel = usum[IDW-1:0];
    end
  end

endmodule

// File: rtl/rr_array_arbiter.sv
// Round-robin arbiter serialising W lane words into one registered
// valid/ready output channel, one word per cycle when the sink keeps up.
module rr_array_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int W   = 4,
  parameter  int DW  = 1,
  localparam int IDW = rr_idw(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid [W-1:0],
  input  logic [DW-1:0]  req_data  [W-1:0],
  output logic           req_ready [W-1:0],
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready,
  output logic           busy
);

  rr_state_e      state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [IDW-1:0] sel;
  logic           hit;
  logic           take;
  logic           accept;

  rr_pick #(.W(W), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .sel       (sel),
    .hit       (hit)
  );

  always_comb begin
    take   = (state_q == IDLE) || ((state_q == SEND) && out_ready);
    accept = take && hit && !rst;
    for (int i = 0; i < W; i++) begin
      req_ready[i] = accept && (sel == IDW'(i));
    end

    state_d    = state_q;
    ptr_d      = ptr_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    if (take) begin
      if (hit) begin
        state_d    = SEND;
        out_data_d = req_data[sel];
        out_id_d   = sel;
        ptr_d      = (sel == IDW'(W - 1)) ? '0 : sel + IDW'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      out_id_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_id_q   <= out_id_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_array_arbiter.sv
// Self-checking bench: directed scenarios on W=4/3/1 instances plus
// randomized traffic against a behavioural round-robin model.
module tb_rr_array_arbiter;

  localparam int WA = 4, DWA = 1;
  localparam int WB = 3, DWB = 4;
  localparam int WC = 1, DWC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: W=4, DW=1
  logic           rst_a;
  logic           a_v   [WA-1:0];
  logic [DWA-1:0] a_d   [WA-1:0];
  logic           a_rdy [WA-1:0];
  logic           a_ov, a_ordy, a_busy;
  logic [DWA-1:0] a_od;
  logic [1:0]     a_oid;
  logic [3:0]     a_rdy_vec;
  assign a_rdy_vec = {a_rdy[3], a_rdy[2], a_rdy[1], a_rdy[0]};

  // Instance B: W=3, DW=4
  logic           rst_b;
  logic           b_v   [WB-1:0];
  logic [DWB-1:0] b_d   [WB-1:0];
  logic           b_rdy [WB-1:0];
  logic           b_ov, b_ordy, b_busy;
  logic [DWB-1:0] b_od;
  logic [1:0]     b_oid;
  logic [2:0]     b_rdy_vec;
  assign b_rdy_vec = {b_rdy[2], b_rdy[1], b_rdy[0]};

  // Instance C: W=1, DW=2
  logic           rst_c;
  logic           c_v   [WC-1:0];
  logic [DWC-1:0] c_d   [WC-1:0];
  logic           c_rdy [WC-1:0];
  logic           c_ov, c_ordy, c_busy;
  logic [DWC-1:0] c_od;
  logic [0:0]     c_oid;

  rr_array_arbiter #(.W(WA), .DW(DWA)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_v), .req_data(a_d), .req_ready(a_rdy),
    .out_valid(a_ov), .out_data(a_od), .out_id(a_oid), .out_ready(a_ordy), .busy(a_busy)
  );

  rr_array_arbiter #(.W(WB), .DW(DWB)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_v), .req_data(b_d), .req_ready(b_rdy),
    .out_valid(b_ov), .out_data(b_od), .out_id(b_oid), .out_ready(b_ordy), .busy(b_busy)
  );

  rr_array_arbiter #(.W(WC), .DW(DWC)) u_dut_c (
    .clk(clk), .rst(rst_c), .req_valid(c_v), .req_data(c_d), .req_ready(c_rdy),
    .out_valid(c_ov), .out_data(c_od), .out_id(c_oid), .out_ready(c_ordy), .busy(c_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [3:0] v, input logic ordy);
    for (int i = 0; i < WA; i++) begin
      a_v[i] = v[i];
      a_d[i] = DWA'($urandom);
    end
    a_ordy = ordy;
  endtask

  task automatic set_b(input logic [2:0] v, input logic ordy);
    for (int i = 0; i < WB; i++) begin
      b_v[i] = v[i];
      b_d[i] = DWB'($urandom);
    end
    b_ordy = ordy;
  endtask

  task automatic set_c(input logic v, input logic ordy);
    c_v[0]  = v;
    c_d[0]  = DWC'($urandom);
    c_ordy  = ordy;
  endtask

  task automatic reset_all();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_a(4'b0, 1'b0);
    set_b(3'b0, 1'b0);
    set_c(1'b0, 1'b0);
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  // Reference pick: first valid index scanning ptr, ptr+1, ... modulo w.
  function automatic int model_sel(input int w, input int ptr, input logic [3:0] v);
    for (int k = 0; k < w; k++) begin
      if (v[(ptr + k) % w]) return (ptr + k) % w;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_a(4'hF, 1'b1);
    set_b(3'h7, 1'b1);
    set_c(1'b1, 1'b1);
    tick();
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({a_rdy_vec, a_ov, a_oid} !== 7'b0)
        $display("FAIL reset_hold: rdy=%b ov=%b id=%0d, want 0000/0/0", a_rdy_vec, a_ov, a_oid);
      else n_pass++;
      tick();
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_rdy_vec !== 4'b0001)
      $display("FAIL reset_first_grant: rdy=%b want 0001", a_rdy_vec);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_oid} !== {1'b1, 2'd0})
      $display("FAIL reset_first_out: ov=%b id=%0d want 1/0", a_ov, a_oid);
    else n_pass++;
    tick();
  endtask

  task automatic test_rotation();
    logic [DWA-1:0] prev_d;
    prev_d = '0;
    reset_all();
    for (int c = 0; c < 7; c++) begin
      set_a(4'hF, 1'b1);
      @(negedge clk);
      n_checks++;
      if (a_rdy_vec !== (4'b0001 << (c % 4)))
        $display("FAIL rotation_ready c=%0d: rdy=%b want %b", c, a_rdy_vec, 4'b0001 << (c % 4));
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if ({a_ov, a_oid, a_od} !== {1'b1, 2'((c - 1) % 4), prev_d})
          $display("FAIL rotation_out c=%0d: ov=%b id=%0d d=%0h want 1/%0d/%0h",
                   c, a_ov, a_oid, a_od, (c - 1) % 4, prev_d);
        else n_pass++;
      end
      prev_d = a_d[c % 4];
      tick();
    end
  endtask

  task automatic test_backpressure();
    reset_all();
    set_a(4'b0100, 1'b0);
    a_d[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_rdy_vec !== 4'b0100) $display("FAIL bp_grant: rdy=%b want 0100", a_rdy_vec);
    else n_pass++;
    tick();
    repeat (5) begin
      set_a(4'b0100, 1'b0);
      a_d[2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({a_rdy_vec, a_ov, a_oid, a_od, a_busy} !== {4'b0000, 1'b1, 2'd2, 1'b1, 1'b1})
        $display("FAIL bp_hold: rdy=%b ov=%b id=%0d d=%0h busy=%b want 0000/1/2/1/1",
                 a_rdy_vec, a_ov, a_oid, a_od, a_busy);
      else n_pass++;
      tick();
    end
    set_a(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_rdy_vec, a_ov} !== {4'b0000, 1'b1})
      $display("FAIL bp_release: rdy=%b ov=%b want 0000/1", a_rdy_vec, a_ov);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_busy} !== 2'b00) $display("FAIL bp_drain: ov=%b busy=%b want 0/0", a_ov, a_busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    reset_all();
    set_a(4'b0100, 1'b1);
    set_b(3'b010, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_rdy_vec, b_rdy_vec} !== {4'b0100, 3'b010})
      $display("FAIL wrap_first: a=%b b=%b want 0100/010", a_rdy_vec, b_rdy_vec);
    else n_pass++;
    tick();
    set_a(4'b1001, 1'b1);
    set_b(3'b101, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_rdy_vec, b_rdy_vec} !== {4'b1000, 3'b100})
      $display("FAIL wrap_last: a=%b b=%b want 1000/100", a_rdy_vec, b_rdy_vec);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({a_rdy_vec, a_oid, b_rdy_vec, b_oid} !== {4'b0001, 2'd3, 3'b001, 2'd2})
      $display("FAIL wrap_zero: a=%b id=%0d b=%b id=%0d want 0001/3/001/2",
               a_rdy_vec, a_oid, b_rdy_vec, b_oid);
    else n_pass++;
    tick();
    set_a(4'b0000, 1'b1);
    set_b(3'b000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_oid, b_ov, b_oid} !== {1'b1, 2'd0, 1'b1, 2'd0})
      $display("FAIL wrap_out: a=%b/%0d b=%b/%0d want 1/0 1/0", a_ov, a_oid, b_ov, b_oid);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_send();
    logic [DWA-1:0] exp_d;
    reset_all();
    set_a(4'b0010, 1'b0);
    tick();
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_oid} !== {1'b1, 2'd1}) $display("FAIL mid_send_pre: ov=%b id=%0d want 1/1", a_ov, a_oid);
    else n_pass++;
    rst_a = 1'b1;
    set_a(4'hF, 1'b1);
    @(negedge clk);
    n_checks++;
    if (a_rdy_vec !== 4'b0000) $display("FAIL mid_send_rst_ready: rdy=%b want 0000", a_rdy_vec);
    else n_pass++;
    tick();
    rst_a = 1'b0;
    set_a(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_rdy_vec} !== 5'b0) $display("FAIL mid_send_drop: ov=%b rdy=%b want 0/0000", a_ov, a_rdy_vec);
    else n_pass++;
    tick();
    set_a(4'hF, 1'b1);
    exp_d = a_d[0];
    @(negedge clk);
    n_checks++;
    if (a_rdy_vec !== 4'b0001) $display("FAIL mid_send_restart: rdy=%b want 0001", a_rdy_vec);
    else n_pass++;
    tick();
    set_a(4'b0000, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({a_ov, a_oid, a_od} !== {1'b1, 2'd0, exp_d})
      $display("FAIL mid_send_out: ov=%b id=%0d d=%0h want 1/0/%0h", a_ov, a_oid, a_od, exp_d);
    else n_pass++;
    tick();
  endtask

  task automatic test_w1();
    bit             mv;
    logic [DWC-1:0] md;
    logic           ordy, exp_rdy;
    mv = 1'b0;
    md = '0;
    reset_all();
    for (int i = 0; i < 40; i++) begin
      ordy = ($urandom_range(0, 3) != 0);
      set_c(i % 2 == 0, ordy);
      exp_rdy = c_v[0] && (!mv || ordy);
      @(negedge clk);
      n_checks++;
      if ({c_rdy[0], c_ov, c_oid} !== {exp_rdy, mv, 1'b0} || $isunknown({c_od, c_busy}))
        $display("FAIL w1_cycle %0d: rdy=%b ov=%b id=%0d d=%0h want %b/%b/0", i, c_rdy[0], c_ov, c_oid, c_od, exp_rdy, mv);
      else n_pass++;
      if (mv) begin
        n_checks++;
        if (c_od !== md) $display("FAIL w1_data %0d: d=%0h want %0h", i, c_od, md);
        else n_pass++;
      end
      if (exp_rdy) begin
        mv = 1'b1;
        md = c_d[0];
      end else if (!mv || ordy) begin
        mv = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit         m_v   [2];
    int         m_ptr [2];
    int         m_id  [2];
    logic [7:0] m_d   [2];
    int         w, s;
    logic [3:0] v, exp_rdy, got_rdy;
    logic       ordy, take, got_ov;
    logic [1:0] got_oid;
    logic [7:0] got_od, in_d;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_ptr[k] = 0; m_id[k] = 0; m_d[k] = '0;
    end
    reset_all();
    for (int i = 0; i < 300; i++) begin
      set_a(4'($urandom) & 4'($urandom | 32'h5), ($urandom_range(0, 3) != 0));
      set_b(3'($urandom), ($urandom_range(0, 3) != 0));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        w = (k == 0) ? WA : WB;
        if (k == 0) begin
          v = {a_v[3], a_v[2], a_v[1], a_v[0]}; ordy = a_ordy;
          got_rdy = a_rdy_vec; got_ov = a_ov; got_oid = a_oid; got_od = 8'(a_od);
        end else begin
          v = {1'b0, b_v[2], b_v[1], b_v[0]}; ordy = b_ordy;
          got_rdy = {1'b0, b_rdy_vec}; got_ov = b_ov; got_oid = b_oid; got_od = 8'(b_od);
        end
        take    = !m_v[k] || ordy;
        s       = model_sel(w, m_ptr[k], v);
        exp_rdy = (take && s >= 0) ? (4'b0001 << s) : 4'b0000;
        n_checks++;
        if ({got_rdy, got_ov} !== {exp_rdy, m_v[k]})
          $display("FAIL random_ready dut%0d cyc %0d: rdy=%b ov=%b want %b/%b", k, i, got_rdy, got_ov, exp_rdy, m_v[k]);
        else n_pass++;
        if (m_v[k]) begin
          n_checks++;
          if ({got_oid, got_od} !== {2'(m_id[k]), m_d[k]})
            $display("FAIL random_out dut%0d cyc %0d: id=%0d d=%0h want %0d/%0h", k, i, got_oid, got_od, m_id[k], m_d[k]);
          else n_pass++;
        end
        if (take && s >= 0) begin
          in_d     = (k == 0) ? 8'(a_d[s]) : 8'(b_d[s]);
          m_v[k]   = 1'b1;
          m_id[k]  = s;
          m_d[k]   = in_d;
          m_ptr[k] = (s + 1) % w;
        end else if (take) begin
          m_v[k] = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_a(4'b0, 1'b0);
    set_b(3'b0, 1'b0);
    set_c(1'b0, 1'b0);
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid_send();
    test_w1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
